// File: rtl/apb_master_bridge.sv
// apb_master_bridge: turns a valid/ready command stream into APB4 transfers and returns responses.
// Optional ACCESS-phase timeout abort is compiled in with `define APB_MASTER_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_strb,
    input  logic [2:0]            cmd_prot,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  busy,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_W-1:0]     PADDR,
    output logic [DATA_W-1:0]     PWDATA,
    output logic [DATA_W/8-1:0]   PSTRB,
    output logic [2:0]            PPROT,
    input  logic [DATA_W-1:0]     PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);
    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("apb_master_bridge: TIMEOUT_CYCLES must be within 1..255");
    end

    logic [1:0] state_r;
    logic       cmd_fire_s;
    logic       rsp_fire_s;
    logic       done_s;
    logic       abort_s;

    // A new command waits until the response slot is empty or draining this cycle.
    assign cmd_ready  = (state_r == ST_IDLE) && (!rsp_valid || rsp_ready);
    assign cmd_fire_s = cmd_valid && cmd_ready;
    assign rsp_fire_s = rsp_valid && rsp_ready;
    assign done_s     = (state_r == ST_ACCESS) && PREADY;
    assign busy       = (state_r != ST_IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] tmo_cnt_r;

    assign abort_s = (state_r == ST_ACCESS) && !PREADY && (tmo_cnt_r == TMO_LAST);

    // Counts ACCESS wait cycles of the current transfer; restarts on every SETUP entry.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            tmo_cnt_r <= 8'd0;
        end else if (cmd_fire_s) begin
            tmo_cnt_r <= 8'd0;
        end else if ((state_r == ST_ACCESS) && !PREADY && !abort_s) begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
        end
    end

    // Timeout flag of the response slot; a normal completion clears it.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rsp_timeout <= 1'b0;
        end else if (done_s) begin
            rsp_timeout <= 1'b0;
        end else if (abort_s) begin
            rsp_timeout <= 1'b1;
        end
    end
`else
    assign abort_s     = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // APB phase sequencing; every bus output is a register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_r <= ST_IDLE;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PADDR   <= {ADDR_W{1'b0}};
            PWDATA  <= {DATA_W{1'b0}};
            PSTRB   <= {STRB_W{1'b0}};
            PPROT   <= 3'b000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_fire_s) begin
                        state_r <= ST_SETUP;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        PWRITE  <= cmd_write;
                        PADDR   <= cmd_addr;
                        PPROT   <= cmd_prot;
                        PWDATA  <= cmd_write ? cmd_wdata : {DATA_W{1'b0}};
                        PSTRB   <= cmd_write ? cmd_strb  : {STRB_W{1'b0}};
                    end
                end
                ST_SETUP: begin
                    state_r <= ST_ACCESS;
                    PENABLE <= 1'b1;
                end
                ST_ACCESS: begin
                    // Address/data stay frozen while the slave stalls.
                    if (done_s || abort_s) begin
                        state_r <= ST_IDLE;
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                end
            endcase
        end
    end

    // Response slot: loaded at completion or abort, released by the rsp handshake.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= {DATA_W{1'b0}};
            rsp_err   <= 1'b0;
        end else if (done_s) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= PWRITE ? {DATA_W{1'b0}} : PRDATA;
            rsp_err   <= PSLVERR;
        end else if (abort_s) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= {DATA_W{1'b0}};
            rsp_err   <= 1'b1;
        end else if (rsp_fire_s) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: transaction-level model checked every cycle plus directed scenarios.
// Honors APB_MASTER_TIMEOUT_EN the same way the design does.
module tb_apb_master_bridge;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = DW / 8;
    localparam int TMO = 16;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [SW-1:0] cmd_strb;
    logic [2:0]    cmd_prot;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
    logic [DW-1:0] rsp_rdata;
    logic          PSEL, PENABLE, PWRITE;
    logic [AW-1:0] PADDR;
    logic [DW-1:0] PWDATA;
    logic [SW-1:0] PSTRB;
    logic [2:0]    PPROT;
    logic [DW-1:0] PRDATA;
    logic          PREADY, PSLVERR;

    apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding transfer, cycles counted from acceptance.
    bit            m_on = 1'b0;
    bit            m_busy, m_write, m_rv, m_err, m_to;
    int            m_k;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [SW-1:0] m_strb;
    logic [2:0]    m_prot;

    always @(negedge PCLK) begin
        bit cr;
        if (m_on) begin
            chk("psel",        PSEL,        m_busy);
            chk("penable",     PENABLE,     m_busy && m_k >= 2);
            chk("busy",        busy,        m_busy);
            chk("paddr",       PADDR,       m_addr);
            chk("pprot",       PPROT,       m_prot);
            if (m_busy) begin
                chk("pwrite",  PWRITE,      m_write);
                chk("pwdata",  PWDATA,      m_wdata);
                chk("pstrb",   PSTRB,       m_strb);
            end
            chk("cmd_ready",   cmd_ready,   !m_busy && (!m_rv || rsp_ready));
            chk("rsp_valid",   rsp_valid,   m_rv);
            chk("rsp_rdata",   rsp_rdata,   m_rdata);
            chk("rsp_err",     rsp_err,     m_err);
            chk("rsp_timeout", rsp_timeout, m_to);
        end
        cr = !m_busy && (!m_rv || rsp_ready);
        if (PRESET) begin
            m_on = 1'b1; m_busy = 1'b0; m_k = 0; m_write = 1'b0; m_rv = 1'b0;
            m_err = 1'b0; m_to = 1'b0; m_addr = '0; m_wdata = '0; m_rdata = '0;
            m_strb = '0; m_prot = 3'b000;
        end else if (m_on) begin
            if (m_rv && rsp_ready) m_rv = 1'b0;
            if (m_busy) begin
                if (m_k >= 2 && PREADY) begin
                    m_busy = 1'b0; m_rv = 1'b1; m_err = PSLVERR; m_to = 1'b0;
                    m_rdata = m_write ? 32'h0 : PRDATA;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (m_k - 1 == TMO && !PREADY) begin
                    m_busy = 1'b0; m_rv = 1'b1; m_err = 1'b1; m_to = 1'b1; m_rdata = 32'h0;
                end
`endif
                else m_k++;
            end else if (cmd_valid && cr) begin
                m_busy = 1'b1; m_k = 1; m_write = cmd_write; m_addr = cmd_addr; m_prot = cmd_prot;
                m_wdata = cmd_write ? cmd_wdata : 32'h0;
                m_strb  = cmd_write ? cmd_strb : 4'h0;
            end
        end
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic junk_cmd();
        cmd_write = 1'($urandom_range(0, 1));
        cmd_addr  = $urandom();
        cmd_wdata = $urandom();
        cmd_strb  = 4'($urandom());
        cmd_prot  = 3'($urandom());
    endtask

    // Offers one command and returns just after the handshake edge.
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [2:0] p);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_strb = s; cmd_prot = p;
        for (int i = 0; i < 50; i++) begin
            if (cmd_ready) begin
                tick();
                cmd_valid = 1'b0;
                junk_cmd();
                return;
            end
            tick();
        end
        chk("cmd_accept", cmd_ready, 1'b1);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int n;
        PRESET = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
        PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h0;
        junk_cmd();
        tick(); tick();
        chk("rst_psel", PSEL, 1'b0);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        PRESET = 1'b0;
        tick();

        // Zero-wait write: SETUP, ACCESS, response on the third edge.
        send(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3'b010);
        chk("w_setup_psel", PSEL, 1'b1);
        chk("w_setup_penable", PENABLE, 1'b0);
        tick();
        chk("w_access_penable", PENABLE, 1'b1);
        chk("w_access_paddr", PADDR, 32'h0000_0010);
        chk("w_access_pwdata", PWDATA, 32'hDEAD_BEEF);
        chk("w_access_pprot", PPROT, 3'b010);
        tick();
        chk("w_rsp_valid", rsp_valid, 1'b1);
        chk("w_rsp_err", rsp_err, 1'b0);
        chk("w_rsp_rdata", rsp_rdata, 32'h0);
        chk("w_done_psel", PSEL, 1'b0);
        tick(); tick();

        // Read with four wait states and a slave error.
        PREADY = 1'b0;
        send(1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 4'hF, 3'b001);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("r_wait_penable", PENABLE, 1'b1);
            chk("r_wait_paddr", PADDR, 32'h0000_0004);
            chk("r_wait_pwrite", PWRITE, 1'b0);
            chk("r_wait_pstrb", PSTRB, 4'h0);
            tick();
        end
        chk("r_last_penable", PENABLE, 1'b1);
        PREADY = 1'b1; PRDATA = 32'h1234_5678; PSLVERR = 1'b1;
        tick();
        PSLVERR = 1'b0; PRDATA = 32'h0;
        chk("r_rsp_valid", rsp_valid, 1'b1);
        chk("r_rsp_rdata", rsp_rdata, 32'h1234_5678);
        chk("r_rsp_err", rsp_err, 1'b1);
        tick(); tick();

        // Back-to-back commands with a stalled response consumer.
        rsp_ready = 1'b0;
        send(1'b1, 32'h0000_0020, 32'h0000_00A5, 4'h3, 3'b000);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0030; cmd_prot = 3'b100;
        chk("b2b_busy_ready", cmd_ready, 1'b0);
        tick(); tick();
        for (int i = 0; i < 5; i++) begin
            chk("b2b_hold_ready", cmd_ready, 1'b0);
            chk("b2b_gap_penable", PENABLE, 1'b0);
            chk("b2b_hold_rsp", rsp_valid, 1'b1);
            if (i < 4) tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("b2b_drain_ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
        junk_cmd();
        chk("b2b_setup_psel", PSEL, 1'b1);
        chk("b2b_setup_penable", PENABLE, 1'b0);
        chk("b2b_setup_paddr", PADDR, 32'h0000_0030);
        chk("b2b_drained", rsp_valid, 1'b0);
        tick(); tick(); tick(); tick();

        // Reset in the second ACCESS wait cycle abandons the transfer.
        PREADY = 1'b0;
        send(1'b0, 32'h0000_0040, 32'h0, 4'h0, 3'b011);
        tick(); tick();
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        chk("rst_mid_psel", PSEL, 1'b0);
        chk("rst_mid_penable", PENABLE, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        PREADY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("rst_mid_no_rsp", rsp_valid, 1'b0);
            tick();
        end

        // Slave never ready.
        PREADY = 1'b0; rsp_ready = 1'b0;
        send(1'b0, 32'h0000_0050, 32'h0, 4'h0, 3'b000);
`ifdef APB_MASTER_TIMEOUT_EN
        n = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (!PENABLE) break;
            n++;
        end
        chk("tmo_access_cycles", n, TMO);
        chk("tmo_rsp_valid", rsp_valid, 1'b1);
        chk("tmo_rsp_err", rsp_err, 1'b1);
        chk("tmo_rsp_timeout", rsp_timeout, 1'b1);
        chk("tmo_rsp_rdata", rsp_rdata, 32'h0);
        tick(); tick();
        PREADY = 1'b1; rsp_ready = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("tmo_late_no_rsp", rsp_valid, 1'b0);
            chk("tmo_late_psel", PSEL, 1'b0);
            tick();
        end
`else
        n = 0;
        tick();
        for (int i = 0; i < 40; i++) begin
            chk("nomacro_penable", PENABLE, 1'b1);
            chk("nomacro_no_rsp", rsp_valid, 1'b0);
            tick();
        end
        PREADY = 1'b1; PRDATA = 32'hCAFE_F00D;
        tick();
        chk("nomacro_rsp_valid", rsp_valid, 1'b1);
        chk("nomacro_rsp_timeout", rsp_timeout, 1'b0);
        chk("nomacro_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
        rsp_ready = 1'b1;
        tick(); tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
